// File: rtl/sfq_pkg.sv
// Shared definitions for the SFQ toggle-line blocks (transmitter now, receiver/monitor later).
package sfq_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_GAP  = 2'd2,
      ST_EMIT = 2'd3
   } sfq_tx_state_t;

   localparam int unsigned SFQ_BEGIN_CYCLES = 8;
   localparam int unsigned SFQ_MIN_GAP      = 2;
   localparam int unsigned SFQ_CNT_W        = 4;
   localparam int unsigned SFQ_TOT_W        = 16;

   // Bits needed to hold max_val; never less than one.
   function automatic int unsigned sfq_cnt_bits(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sfq_pulse_tx_if.sv
// Request handshake and pulse-line outputs of the SFQ transmitter.
interface sfq_pulse_tx_if #(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned TOT_W = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [CNT_W-1:0] req_count;
   logic             q;
   logic             pulse;
   logic             busy;
   logic [TOT_W-1:0] sent_total;

   modport master (
      output req_valid, req_count,
      input  req_ready, q, pulse, busy, sent_total
   );

   modport slave (
      input  req_valid, req_count,
      output req_ready, q, pulse, busy, sent_total
   );
endinterface

// File: rtl/sfq_gap_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module sfq_gap_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)                cnt_d = load_val;
      else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);
endmodule

// File: rtl/sfq_pulse_tx.sv
// Toggle-encoded SFQ pulse transmitter: counted bursts with start-up blanking and
// a fixed minimum spacing between q transitions.
module sfq_pulse_tx
   import sfq_pkg::*;
#(
   parameter int unsigned BEGIN_CYCLES = SFQ_BEGIN_CYCLES,
   parameter int unsigned MIN_GAP      = SFQ_MIN_GAP,
   parameter int unsigned CNT_W        = SFQ_CNT_W,
   parameter int unsigned TOT_W        = SFQ_TOT_W
) (
   input logic            clk,
   input logic            rst,
   sfq_pulse_tx_if.slave  tx
);
   // Blanking loads BEGIN_CYCLES-1 on its first INIT edge; spacing loads MIN_GAP-2
   // at each toggle so the next toggle lands exactly MIN_GAP edges later.
   localparam int unsigned INIT_LD = (BEGIN_CYCLES > 0) ? BEGIN_CYCLES - 1 : 0;
   localparam int unsigned GAP_LD  = (MIN_GAP > 1) ? MIN_GAP - 2 : 0;
   localparam int unsigned TMR_W   = sfq_cnt_bits((INIT_LD > GAP_LD) ? INIT_LD : GAP_LD);
   localparam logic [TMR_W-1:0] INIT_LD_V = TMR_W'(INIT_LD);
   localparam logic [TMR_W-1:0] GAP_LD_V  = TMR_W'(GAP_LD);

   sfq_tx_state_t    state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [TOT_W-1:0] total_q, total_d;
   logic             q_q, q_d;
   logic             pulse_q;
   logic             armed_q, armed_d;
   logic             fire;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_done;

   sfq_gap_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      total_d  = total_q;
      q_d      = q_q;
      armed_d  = armed_q;
      fire     = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = GAP_LD_V;

      case (state_q)
         ST_INIT: begin
            if (BEGIN_CYCLES == 0 || (armed_q && tmr_done)) begin
               state_d = ST_IDLE;
            end else if (!armed_q) begin
               armed_d  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = INIT_LD_V;
            end
         end
         ST_IDLE: begin
            if (tx.req_valid && tx.req_count != '0) begin
               fire  = 1'b1;
               rem_d = tx.req_count - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (tmr_done) state_d = (rem_q != '0) ? ST_EMIT : ST_IDLE;
         end
         ST_EMIT: begin
            fire  = 1'b1;
            rem_d = rem_q - CNT_W'(1);
         end
         default: state_d = ST_INIT;
      endcase

      // Every pulse, first or subsequent, shares the same toggle and follow-on logic.
      if (fire) begin
         q_d     = ~q_q;
         total_d = total_q + TOT_W'(1);
         if (MIN_GAP > 1) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD_V;
         end else begin
            state_d = (rem_d != '0) ? ST_EMIT : ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         rem_q   <= '0;
         total_q <= '0;
         q_q     <= 1'b0;
         pulse_q <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         total_q <= total_d;
         q_q     <= q_d;
         pulse_q <= fire;
         armed_q <= armed_d;
      end
   end

   assign tx.req_ready  = (state_q == ST_IDLE);
   assign tx.busy       = (state_q != ST_IDLE);
   assign tx.q          = q_q;
   assign tx.pulse      = pulse_q;
   assign tx.sent_total = total_q;
endmodule
